// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit scheduler.
//   state_t   - scheduler FSM encoding (2 bits)
//   N_REQ_DEF - default number of byte producers
//   clog2()   - ceiling log2, usable in parameter defaults
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int unsigned N_REQ_DEF = 4;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among the requesters.
//   req   - pending-byte levels
//   ptr   - last served index; the search starts at ptr+1
//   lock  - a message is in progress; only owner may win
//   owner - current message owner
//   grant - one-hot winner (all zero when nothing is eligible)
//   idx   - binary index of the winner
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             lock,
  input  logic [ID_W-1:0]  owner,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic [N_REQ-1:0] elig;
  logic [ID_W-1:0]  cand;
  logic             found;

  // Walk ptr+1, ptr+2, ... wrapping; the first eligible requester wins.
  always_comb begin
    elig  = lock ? (req & (N_REQ'(1) << owner)) : req;
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = ID_W'((32'(ptr) + i) % N_REQ);
      if (!found && elig[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter among N_REQ byte producers.
// Arbitrates round-robin (with per-message lock), latches the winning byte,
// strobes the transmitter, gates the baud generator and detects a transmitter
// that never leaves ready after a start.
//   req/req_data/req_last - producer side; ack pulses when a byte is taken
//   tx_din/tx_start       - to tx.din / tx.tx_out_en
//   tx_ready              - from tx.ready (high = idle)
//   baud_en               - to baud_gen.ena
//   busy/owner            - status; err_timeout pulses on a stall
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned N_REQ   = N_REQ_DEF,
  parameter int unsigned ID_W    = clog2(N_REQ),
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   ack,
  output logic [7:0]         tx_din,
  output logic               tx_start,
  input  logic               tx_ready,
  output logic               baud_en,
  output logic               busy,
  output logic [ID_W-1:0]    owner,
  output logic               err_timeout
);

  localparam int unsigned CNT_W = clog2(TIMEOUT + 1);

  state_t           state;
  logic [ID_W-1:0]  ptr;
  logic             locked;
  logic [CNT_W-1:0] cnt;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .lock  (locked),
    .owner (owner),
    .grant (grant),
    .idx   (idx)
  );

  // Scheduler FSM with all outputs registered; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ack         <= '0;
      tx_din      <= 8'h00;
      tx_start    <= 1'b0;
      baud_en     <= 1'b0;
      busy        <= 1'b0;
      owner       <= '0;
      err_timeout <= 1'b0;
      locked      <= 1'b0;
      ptr         <= ID_W'(N_REQ - 1);
      cnt         <= '0;
    end else begin
      ack         <= '0;
      tx_start    <= 1'b0;
      err_timeout <= 1'b0;
      case (state)
        IDLE: begin
          // An abandoned message releases the lock without granting this cycle.
          if (locked && !req[owner]) begin
            locked <= 1'b0;
          end else if (tx_ready && (grant != '0)) begin
            tx_din  <= req_data[{idx, 3'b000} +: 8];
            owner   <= idx;
            ack     <= grant;
            locked  <= ~req_last[idx];
            busy    <= 1'b1;
            baud_en <= 1'b1;
            state   <= START;
          end
        end
        START: begin
          tx_start <= 1'b1;
          cnt      <= '0;
          state    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!tx_ready) begin
            state <= WAIT_DONE;
          end else if (cnt >= CNT_W'(TIMEOUT - 1)) begin
            // Stall: give up on this byte and free the transmitter slot.
            err_timeout <= 1'b1;
            locked      <= 1'b0;
            ptr         <= owner;
            busy        <= 1'b0;
            baud_en     <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            ptr     <= owner;
            busy    <= 1'b0;
            baud_en <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Round-robin scheduler that shares one UART transmitter among N_REQ byte producers. It arbitrates, latches the winning byte, and drives the transmitter's data/enable inputs. It also gates the baud generator and watches the transmitter's `ready` handshake for a stall. The block sits between the application logic and the existing tx/baud_gen pair and replaces hand-written per-design sequencing FSMs.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `ID_W`, 2: owner index width, equal to clog2(N_REQ).
- `TIMEOUT`, 4095: clock cycles allowed for the transmitter to leave ready after a start.

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req`  in  N_REQ  per-requester byte-pending level.
- `req_data`  in  8*N_REQ  byte i on bits [8i+7:8i]; held stable while req[i] is high.
- `req_last`  in  N_REQ  byte is last of a message; releases the lock.
- `ack`  out  N_REQ  one-cycle pulse: byte of requester i latched.
- `tx_din`  out  8  byte to transmitter.
- `tx_start`  out  1  one-cycle start/enable strobe to transmitter.
- `tx_ready`  in  1  transmitter idle (high) / shifting (low).
- `baud_en`  out  1  enable for the baud generator.
- `busy`  out  1  state is not IDLE.
- `owner`  out  ID_W  index of the current or last granted requester.
- `err_timeout`  out  1  one-cycle pulse when a stall is detected.

## Operation
States: IDLE, START, WAIT_BUSY, WAIT_DONE (2-bit encoding).
- IDLE: if tx_ready=1 and any eligible req, the block does the following on the edge:
  - picks the winner, latches req_data into tx_din, sets owner, pulses ack[winner];
  - latches req_last into `locked_n`, then moves to START.
  - Otherwise it stays in IDLE.
- Eligibility:
  - When unlocked, all req bits are eligible. Round-robin search starts at ptr+1 mod N_REQ.
  - When locked, only req[owner] is eligible.
  - If req[owner] is 0 while locked in IDLE, the lock is dropped that cycle and normal arbitration resumes on the next cycle.
- START: tx_start=1 for exactly one cycle. Clear the timeout counter, then go to WAIT_BUSY.
- WAIT_BUSY:
  - tx_ready=0 → WAIT_DONE.
  - Counter reaches TIMEOUT → pulse err_timeout, clear the lock, go to IDLE. ptr still updates.
- WAIT_DONE: tx_ready=1 → IDLE, and ptr←owner. There is no timeout here, because frame length is bounded by the transmitter.
- baud_en=1 in START, WAIT_BUSY and WAIT_DONE; 0 in IDLE.
- tx_din holds its value from the latch edge until the next latch.
- Simultaneous events:
  - A new req arriving in the same cycle the FSM enters IDLE is evaluated on the following edge.
  - req toggling in non-IDLE states is ignored.
- Counter width is clog2(TIMEOUT+1), saturating; it never wraps.

## Timing
- Reset values: ack=0, tx_din=0x00, tx_start=0, baud_en=0, busy=0, owner=0, err_timeout=0, state=IDLE, lock clear, ptr=N_REQ-1 (so requester 0 wins first).
- Reset mid-frame: all outputs return to reset values immediately (asynchronous). The pending byte is dropped and no ack is reissued.
- Latency:
  - req sampled high at edge k → ack and tx_din valid after edge k.
  - tx_start high after edge k+1.
  - Earliest WAIT_BUSY exit is edge k+3.
- Back-to-back throughput: one frame + 2 clk idle gap (WAIT_DONE→IDLE, IDLE→START).
- All outputs are registered.

## Structure
- Package `uart_pkg`: state enum/localparams (IDLE=0, START=1, WAIT_BUSY=2, WAIT_DONE=3), default N_REQ, and the clog2 helper function.
- Sub-module `rr_arbiter`: combinational; inputs are the req vector, ptr, lock and owner; outputs are a one-hot grant plus an index. The scheduler owns ptr and all registers.
- Top-level integration: tx_din→tx.din, tx_start→tx.tx_out_en, tx.ready→tx_ready, baud_en→baud_gen.ena.

## Test plan
- Single request: req[2]=1, data 0x41, last=1.
  - ack[2] one cycle later; tx_din=0x41; tx_start one cycle after that; owner=2.
  - After tx_ready low then high: busy=0, baud_en=0.
- Fairness: all four reqs held high with last=1 over 8 frames.
  - Grant order is 0,1,2,3,0,1,2,3; each ack is a single-cycle pulse.
- Message lock: req[1] sends 3 bytes (last=0,0,1) while req[0] and req[3] are held.
  - All three bytes go to requester 1 consecutively, then requester 3, then requester 0.
- Stall: tx_ready held at 1 after tx_start, with TIMEOUT=15.
  - err_timeout pulses exactly 15 cycles after entering WAIT_BUSY; state returns to IDLE; next req is served normally.
- Async reset in WAIT_DONE: assert rst_n=0 mid-frame.
  - All outputs read reset values in the same cycle; after release, requester 0 wins first.
- Lock abort: owner 2 locked with last=0, then drops req[2] while req[0]=1.
  - Lock clears; requester 0 is acked 2 cycles after entering IDLE.
